// File: rtl/qar_irq_pkg.sv
// Shared constants and types for the qar interrupt controller.
package qar_irq_pkg;

    localparam int unsigned ADDR_W          = 6;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ID_W            = 5;
    localparam int unsigned PRIO_W          = 2;
    localparam int unsigned CLAIM_VALID_BIT = 31;

    localparam int unsigned STAT_BUSY_BIT   = 0;
    localparam int unsigned STAT_ERR_BIT    = 1;
    localparam int unsigned STAT_ID_LSB     = 8;

    localparam logic [ADDR_W-1:0] IRQ_PENDING   = 6'h0;
    localparam logic [ADDR_W-1:0] IRQ_ENABLE    = 6'h1;
    localparam logic [ADDR_W-1:0] IRQ_EDGE      = 6'h2;
    localparam logic [ADDR_W-1:0] IRQ_PRIORITY  = 6'h3;
    localparam logic [ADDR_W-1:0] IRQ_CLAIM     = 6'h4;
    localparam logic [ADDR_W-1:0] IRQ_COMPLETE  = 6'h5;
    localparam logic [ADDR_W-1:0] IRQ_THRESHOLD = 6'h6;
    localparam logic [ADDR_W-1:0] IRQ_STATUS    = 6'h7;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_CLAIMED = 1'b1
    } irq_state_e;

endpackage

// File: rtl/qar_irq_prio_tree.sv
// Combinational selector: highest priority eligible source, ties to lowest index.
module qar_irq_prio_tree
    import qar_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]        eligible,
    input  logic [PRIO_W*NUM_SRC-1:0] prio,
    output logic                      valid,
    output logic [ID_W-1:0]           id
);

    logic [PRIO_W-1:0] best_prio;

    // Only a strictly higher priority displaces an earlier winner, so ties keep the lower index.
    always_comb begin
        valid     = 1'b0;
        id        = '0;
        best_prio = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!valid || (prio[PRIO_W*i +: PRIO_W] > best_prio))) begin
                valid     = 1'b1;
                id        = ID_W'(i);
                best_prio = prio[PRIO_W*i +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/qar_irq_ctrl.sv
// Register-mapped interrupt controller with claim/complete handshake.
// Define QAR_IRQ_EDGE_EN to build the EDGE register and sticky edge-mode pending bits.
module qar_irq_ctrl
    import qar_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bus_write,
    input  logic               bus_read,
    input  logic [5:0]         addr_word,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic               cpu_irq
);

    localparam int unsigned PRIO_VEC_W = PRIO_W * NUM_SRC;

    irq_state_e             state_q, state_d;
    logic [NUM_SRC-1:0]     src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0]     enable_q, enable_d;
    logic [NUM_SRC-1:0]     in_service_q, in_service_d;
    logic [PRIO_VEC_W-1:0]  prio_q, prio_d;
    logic [PRIO_W-1:0]      thresh_q, thresh_d;
    logic [ID_W-1:0]        claimed_id_q, claimed_id_d;
    logic                   cmpl_err_q, cmpl_err_d;

    logic [NUM_SRC-1:0]     pending;
    logic [NUM_SRC-1:0]     edge_mode;
    logic [NUM_SRC-1:0]     eligible;
    logic [NUM_SRC-1:0]     claim_onehot;
    logic                   best_valid;
    logic [ID_W-1:0]        best_id;

    logic wr_enable, wr_prio, wr_complete, wr_thresh, wr_status;
    logic claim_fire, cmpl_ok;

    assign wr_enable   = bus_write && (addr_word == IRQ_ENABLE);
    assign wr_prio     = bus_write && (addr_word == IRQ_PRIORITY);
    assign wr_complete = bus_write && (addr_word == IRQ_COMPLETE);
    assign wr_thresh   = bus_write && (addr_word == IRQ_THRESHOLD);
    assign wr_status   = bus_write && (addr_word == IRQ_STATUS);

    // A claim only takes effect when the read actually returns a valid id.
    assign claim_fire   = bus_read && (addr_word == IRQ_CLAIM) && (state_q == IRQ_IDLE) && best_valid;
    assign cmpl_ok      = wr_complete && (state_q == IRQ_CLAIMED) && (wdata[ID_W-1:0] == claimed_id_q);
    assign claim_onehot = NUM_SRC'(1) << best_id;
    assign src_prev_d   = src_irq;

`ifdef QAR_IRQ_EDGE_EN
    logic               wr_pending, wr_edge;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] sticky_q, sticky_d;
    logic [NUM_SRC-1:0] sticky_clr;

    assign wr_pending = bus_write && (addr_word == IRQ_PENDING);
    assign wr_edge    = bus_write && (addr_word == IRQ_EDGE);

    // Sticky edge capture; a new rising edge always beats any clear in the same cycle.
    always_comb begin
        edge_d     = edge_q;
        sticky_clr = '0;
        if (wr_edge) begin
            edge_d     = wdata[NUM_SRC-1:0];
            sticky_clr = sticky_clr | (edge_q ^ wdata[NUM_SRC-1:0]);
        end
        if (wr_pending) begin
            sticky_clr = sticky_clr | (wdata[NUM_SRC-1:0] & edge_q);
        end
        if (claim_fire) begin
            sticky_clr = sticky_clr | (claim_onehot & edge_q);
        end
        sticky_d = (sticky_q & ~sticky_clr) | (src_irq & ~src_prev_q & edge_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q   <= '0;
            sticky_q <= '0;
        end else begin
            edge_q   <= edge_d;
            sticky_q <= sticky_d;
        end
    end

    assign edge_mode = edge_q;
    assign pending   = (edge_q & sticky_q) | (~edge_q & src_prev_q);
`else
    assign edge_mode = '0;
    assign pending   = src_prev_q;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending[i] && enable_q[i] && !in_service_q[i]
                          && (prio_q[PRIO_W*i +: PRIO_W] > thresh_q);
        end
    end

    qar_irq_prio_tree #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_tree (
        .eligible (eligible),
        .prio     (prio_q),
        .valid    (best_valid),
        .id       (best_id)
    );

    assign cpu_irq = (state_q == IRQ_IDLE) && best_valid;

    // Config registers, claim/complete state machine and error flag.
    always_comb begin
        state_d      = state_q;
        enable_d     = enable_q;
        prio_d       = prio_q;
        thresh_d     = thresh_q;
        in_service_d = in_service_q;
        claimed_id_d = claimed_id_q;
        cmpl_err_d   = cmpl_err_q;

        if (wr_enable) enable_d = wdata[NUM_SRC-1:0];
        if (wr_prio)   prio_d   = wdata[PRIO_VEC_W-1:0];
        if (wr_thresh) thresh_d = wdata[PRIO_W-1:0];
        if (wr_status && wdata[STAT_ERR_BIT]) cmpl_err_d = 1'b0;

        case (state_q)
            IRQ_IDLE: begin
                if (claim_fire) begin
                    state_d      = IRQ_CLAIMED;
                    in_service_d = in_service_q | claim_onehot;
                    claimed_id_d = best_id;
                end
            end
            IRQ_CLAIMED: begin
                if (cmpl_ok) begin
                    state_d      = IRQ_IDLE;
                    in_service_d = in_service_q & ~(NUM_SRC'(1) << claimed_id_q);
                    claimed_id_d = '0;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase

        if (wr_complete && !cmpl_ok) cmpl_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IRQ_IDLE;
            src_prev_q   <= '0;
            enable_q     <= '0;
            in_service_q <= '0;
            prio_q       <= '0;
            thresh_q     <= '0;
            claimed_id_q <= '0;
            cmpl_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_prev_q   <= src_prev_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
            prio_q       <= prio_d;
            thresh_q     <= thresh_d;
            claimed_id_q <= claimed_id_d;
            cmpl_err_q   <= cmpl_err_d;
        end
    end

    // Read mux; zero when no read strobe.
    always_comb begin
        rdata = '0;
        if (bus_read) begin
            case (addr_word)
                IRQ_PENDING:   rdata = DATA_W'(pending);
                IRQ_ENABLE:    rdata = DATA_W'(enable_q);
                IRQ_EDGE:      rdata = DATA_W'(edge_mode);
                IRQ_PRIORITY:  rdata = DATA_W'(prio_q);
                IRQ_CLAIM: begin
                    if ((state_q == IRQ_IDLE) && best_valid) begin
                        rdata[CLAIM_VALID_BIT] = 1'b1;
                        rdata[ID_W-1:0]        = best_id;
                    end
                end
                IRQ_THRESHOLD: rdata = DATA_W'(thresh_q);
                IRQ_STATUS: begin
                    rdata[STAT_BUSY_BIT]             = (state_q == IRQ_CLAIMED);
                    rdata[STAT_ERR_BIT]              = cmpl_err_q;
                    rdata[STAT_ID_LSB +: ID_W]       = claimed_id_q;
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/qar_irq_ctrl.md
# qar_irq_ctrl

Interrupt controller that sits directly downstream of the timer and other memory-mapped peripherals. It gathers their `irq` lines and latches them as pending, masks and prioritises them, and drives a single `cpu_irq` to the core. Software acknowledges interrupts through a claim/complete register handshake. The block uses the same word-addressed register bus as the peripherals it serves.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of interrupt sources, 1..16; source 0 is the timer by convention.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `bus_write`  in  1  register write strobe, one cycle
- `bus_read`  in  1  register read strobe, one cycle
- `addr_word`  in  6  word address
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational, 0 when `!bus_read`
- `src_irq`  in  NUM_SRC  peripheral interrupt lines, synchronous to `clk`
- `cpu_irq`  out  1  interrupt request to core, combinational from registers

## Operation
Registers by word address; unused bits read 0 and unlisted addresses read 0.
- 0x0 PENDING (RO):
  - Level-mode bits mirror registered `src_irq`.
  - Edge-mode bits are sticky.
  - Writing 1 clears an edge-mode bit.
- 0x1 ENABLE (RW): per-source mask.
- 0x2 EDGE (RW): 1 selects rising-edge mode.
- 0x3 PRIORITY (RW): 2 bits per source at `[2i+1:2i]`. Priority 0 never interrupts.
- 0x4 CLAIM (RO with side effect):
  - Returns `{1'b1, 26'b0, id[4:0]}` for the best eligible source, else 0.
  - A read that returns valid performs the claim.
- 0x5 COMPLETE (WO): `wdata[4:0]` is the id being completed.
- 0x6 THRESHOLD (RW, 2 bits): only priorities strictly greater than this value are eligible.
- 0x7 STATUS:
  - bit0 `busy` (state CLAIMED).
  - bit1 `cmpl_err`, sticky, cleared by writing 1 to it.
  - `[12:8]` claimed id.

Eligibility and selection:
- A source is eligible when pending & enabled & ~in_service & prio > threshold.
- The highest priority wins; ties go to the lowest index.
- `cpu_irq` = (state == IDLE) & any source eligible.

State machine:
- IDLE → CLAIMED on a valid CLAIM read. On the next edge: set `in_service[id]`, latch `claimed_id`, and clear the pending bit if the source is edge mode.
- CLAIMED → IDLE on a COMPLETE write with id == `claimed_id`. On the next edge: clear `in_service[id]`.
- COMPLETE with a mismatched id, or written in IDLE: the write is ignored and `cmpl_err` is set.
- CLAIM read in CLAIMED returns 0. Nesting is not supported.

## Timing
- Reset:
  - All registers are 0: PENDING, ENABLE, EDGE, PRIORITY, THRESHOLD, STATUS, `in_service`, `src_prev`.
  - State is IDLE.
  - `cpu_irq` = 0. `rdata` = 0.
- `src_irq` is sampled each cycle into `src_prev`.
  - Level-mode PENDING = `src_prev`.
  - An edge (`src_irq & ~src_prev`) sets the sticky bit on the next edge.
- Latency from `src_irq` rising at edge N to `cpu_irq` high after edge N+1: 1 cycle.
- CLAIM read at cycle N: `rdata` is valid in cycle N, and `cpu_irq` drops after edge N+1.
- Edge arriving in the same cycle as a claim of the same source: set wins, so the bit stays pending.
- Edge arriving in the same cycle as a W1C on PENDING: set wins.
- A level source that is still high after COMPLETE re-asserts `cpu_irq` on the cycle after completion.
- Writing EDGE clears the pending bits of the sources whose mode changed.
- Asynchronous reset mid-claim returns to IDLE and drops everything in service.

## Configuration
- `QAR_IRQ_EDGE_EN` defined: EDGE register and edge detection are present as described above.
- `QAR_IRQ_EDGE_EN` undefined:
  - All sources are level mode.
  - EDGE reads 0 and ignores writes.
  - No sticky pending flops; PENDING write-1-to-clear has no effect.

## Structure
- Package `qar_irq_pkg` holds:
  - address constants `IRQ_PENDING`..`IRQ_STATUS`;
  - the state enum `{IRQ_IDLE, IRQ_CLAIMED}`;
  - `CLAIM_VALID_BIT` = 31;
  - `ID_W` = 5.
- Sub-module `qar_irq_prio_tree` is purely combinational. It takes the eligible vector and packed priorities and produces `{valid, id}`.

## Test plan
- Timer irq (src0, prio 1, enabled, threshold 0) rises → `cpu_irq` high 1 cycle later; CLAIM reads 0x8000_0000; `cpu_irq` low; COMPLETE 0 → IDLE; level still high → `cpu_irq` re-asserts.
- src2 prio 3 and src1 prio 3 pending together → CLAIM returns id 1. After COMPLETE 1, CLAIM returns id 2.
- src3 prio 2 with threshold 2 → no `cpu_irq`. Set threshold 1 → `cpu_irq` high.
- Edge mode on src4: 1-cycle pulse → PENDING bit4 stays set; claim clears it. A second pulse in the claim cycle leaves it set.
- COMPLETE 5 while id 1 is claimed → state stays CLAIMED and STATUS = 0x0000_0103. Writing 0x2 to STATUS clears `cmpl_err`.
- Assert `rst_n` low during CLAIMED → STATUS 0, `cpu_irq` 0, all registers 0 after release.
